// File: rtl/tl45_pkg.sv
// tl45_pkg: opcodes, bubble encoding and fetch FSM states shared across the tl45 pipeline.
package tl45_pkg;
    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_NOT  = 4'h5;
    localparam logic [3:0] OP_SHF  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'h7;
    localparam logic [3:0] OP_LW   = 4'h8;
    localparam logic [3:0] OP_SW   = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hA;
    localparam logic [3:0] OP_CALL = 4'hB;
    localparam logic [3:0] OP_RET  = 4'hC;
    localparam logic [3:0] OP_LEA  = 4'hD;
    localparam logic [3:0] OP_BUBBLE = 4'hF;
    localparam logic [31:0] BUBBLE_INST = 32'hF000_0000;

    typedef enum logic [1:0] {S_FETCH, S_DISCARD, S_HOLD, S_HALT} fetch_state_t;
endpackage

// File: rtl/tl45_fetch.sv
// tl45_fetch: PC register and req/ack instruction fetch feeding decode, with
// stall skid register, flush/redirect of stale requests and HALT parking.
module tl45_fetch
    import tl45_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_pipe_stall,
    input  logic        i_pipe_flush,
    input  logic [31:0] i_new_pc,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_data,
    output logic [31:0] o_buf_pc,
    output logic [31:0] o_buf_inst
);
    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_skid_pc;
    logic [31:0]  r_skid_inst;
    logic         w_data_halt;
    logic         w_skid_halt;

    assign o_mem_req   = (r_state == S_FETCH) || (r_state == S_DISCARD);
    assign w_data_halt = i_mem_data[31:28] == OP_HALT;
    assign w_skid_halt = r_skid_inst[31:28] == OP_HALT;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            o_mem_addr  <= RESET_PC;
            o_buf_pc    <= '0;
            o_buf_inst  <= BUBBLE_INST;
            r_skid_pc   <= '0;
            r_skid_inst <= BUBBLE_INST;
        end else if (i_pipe_flush) begin
            o_buf_inst <= BUBBLE_INST;
            r_pc       <= i_new_pc;
            // An outstanding request must still be acked before redirecting the address.
            if (o_mem_req && !i_mem_ack) begin
                r_state <= S_DISCARD;
            end else begin
                r_state    <= S_FETCH;
                o_mem_addr <= i_new_pc;
            end
        end else begin
            case (r_state)
                S_DISCARD: begin
                    if (i_mem_ack) begin
                        r_state    <= S_FETCH;
                        o_mem_addr <= r_pc;
                    end else if (!i_pipe_stall) begin
                        o_buf_inst <= BUBBLE_INST;
                    end
                end
                S_FETCH: begin
                    if (i_mem_ack && !i_pipe_stall) begin
                        o_buf_pc   <= r_pc;
                        o_buf_inst <= i_mem_data;
                        r_pc       <= r_pc + 32'd1;
                        if (w_data_halt) r_state <= S_HALT;
                        else o_mem_addr <= r_pc + 32'd1;
                    end else if (i_mem_ack) begin
                        r_skid_pc   <= r_pc;
                        r_skid_inst <= i_mem_data;
                        r_pc        <= r_pc + 32'd1;
                        r_state     <= S_HOLD;
                    end else if (!i_pipe_stall) begin
                        o_buf_inst <= BUBBLE_INST;
                    end
                end
                S_HOLD: begin
                    if (!i_pipe_stall) begin
                        o_buf_pc   <= r_skid_pc;
                        o_buf_inst <= r_skid_inst;
                        r_state    <= w_skid_halt ? S_HALT : S_FETCH;
                        o_mem_addr <= r_pc;
                    end
                end
                default: begin
                    if (!i_pipe_stall) o_buf_inst <= BUBBLE_INST;
                end
            endcase
        end
    end
endmodule

// File: doc/tl45_fetch.md
# tl45_fetch

Instruction fetch stage of the tl45 core, directly upstream of decode. Holds the PC and fetches one 32-bit instruction word per request over a req/ack memory port. Presents `{pc, inst}` to the decode input buffer, honouring pipeline stall and flush/redirect. Stops fetching after delivering a HALT until redirected.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.

Ports:
- `i_clk`, in, 1: clock.
- `i_reset`, in, 1: asynchronous, active-high reset.
- `i_pipe_stall`, in, 1: downstream stall; decode does not consume `o_buf_*` this cycle.
- `i_pipe_flush`, in, 1: redirect request; valid for one cycle.
- `i_new_pc`, in, 32: redirect target; sampled only when `i_pipe_flush`=1.
- `o_mem_req`, out, 1: memory read request; held high until ack.
- `o_mem_addr`, out, 32: word address; stable while `o_mem_req`=1.
- `i_mem_ack`, in, 1: one-cycle pulse; `i_mem_data` valid this cycle.
- `i_mem_data`, in, 32: instruction word.
- `o_buf_pc`, out, 32: PC of the presented instruction.
- `o_buf_inst`, out, 32: presented instruction; bubble = `32'hF000_0000`.

## Operation
- PC is word-addressed; next PC = PC+1, modulo 2^32 (0xFFFF_FFFF wraps to 0).
- State machine:
  - `S_FETCH`: `o_mem_req`=1 with `o_mem_addr`=pc.
  - `S_DISCARD`: request still outstanding for a stale address. `o_mem_req`=1; `o_mem_addr` keeps the stale value.
  - `S_HOLD`: fetched word is held in a skid register because decode was stalled. `o_mem_req`=0.
  - `S_HALT`: a HALT (opcode 4'b0111) has been delivered. `o_mem_req`=0.
- Rules are listed in priority order. "Present X" means `o_buf_*` <= X.
- **Flush (any state)**:
  - Present bubble; pc <= `i_new_pc`.
  - Next state is `S_DISCARD` if the current state is `S_FETCH` or `S_DISCARD` and `i_mem_ack`=0. The address register then keeps the stale address until the ack.
  - Otherwise next state is `S_FETCH` with `o_mem_addr` <= `i_new_pc`. Any ack data arriving in the flush cycle is dropped.
- **`S_DISCARD`, ack**: drop the data; go to `S_FETCH` with `o_mem_addr` <= pc. Without ack: stay; present bubble if not stalled.
- **`S_FETCH`, ack, not stalled**:
  - Present `{pc, i_mem_data}`; pc <= pc+1.
  - If `i_mem_data[31:28]`=HALT, go to `S_HALT`.
  - Otherwise stay in `S_FETCH` with `o_mem_addr` <= pc+1.
- **`S_FETCH`, ack, stalled**: capture `{pc, i_mem_data}` into the skid register; pc <= pc+1; go to `S_HOLD`; `o_buf_*` hold.
- **`S_FETCH`, no ack**: present bubble if not stalled; hold if stalled.
- **`S_HOLD`, not stalled**: present the skid contents. Then go to `S_HALT` if the skid opcode is HALT, else to `S_FETCH` with `o_mem_addr` <= pc. Stalled: remain.
- **`S_HALT`**: present bubble when not stalled. Exit only via flush.
- **Any non-flush cycle with `i_pipe_stall`=1**: `o_buf_*` hold their value. Flush overrides stall.

## Timing
- Reset (async) values:
  - state `S_FETCH`, pc = `RESET_PC`, `o_mem_addr` = `RESET_PC`.
  - `o_mem_req`=1 from the first cycle after reset release.
  - `o_buf_pc`=0, `o_buf_inst`=32'hF000_0000, skid register = bubble.
- `o_mem_req` is decoded from state only (no combinational path from inputs).
- Memory that acks in the same cycle a request is seen gives one instruction per cycle.
- Latency: ack in cycle N → instruction on `o_buf_*` in cycle N+1 if not stalled.
- Flush in cycle N → bubble on `o_buf_*` in N+1.
  - If no request was outstanding, the request to `i_new_pc` is visible in N+1.
  - Otherwise it follows one cycle after the stale ack.
- Reset mid-request abandons the transaction. The memory side must tolerate a dropped request.

## Structure
- Shared package `tl45_pkg` holds:
  - opcode constants (`OP_ADD`..`OP_LEA`, `OP_HALT`);
  - `BUBBLE_INST` = 32'hF000_0000 and bubble opcode 4'hF, shared with decode;
  - fetch state enum.
- Single module. No sub-module needed; the skid register is inline.

## Test plan
- Reset, zero-wait memory returning inst = addr+0x0010_0000 (RESET_PC=0) → `o_buf_pc` 0,1,2,3 on consecutive cycles, inst matching.
- Stall for 3 cycles while ack arrives at pc=5 → `S_HOLD`, `o_mem_req`=0. After stall release, `{5, inst}` presented once, then fetch resumes at 6.
- Flush to 0x40 while a request to 0x7 is outstanding (ack 2 cycles later) → stale data dropped, bubble presented; next request addr 0x40, first delivered pc 0x40.
- Flush coinciding with ack → ack data dropped; next request addr = `i_new_pc` on the following cycle.
- Fetch 32'h7000_0000 at pc 9 → delivered, then `o_mem_req`=0 and only bubbles. Flush to 0x20 → fetching resumes at 0x20.
- pc=0xFFFF_FFFF fetched → next `o_mem_addr`=0. Assert `i_reset` mid-wait → outputs immediately return to reset values.
